uart_status_tx: RTL and testbench
=================================

UART_STATUS_TX -- requirements
Module: uart_status_tx

Interface
REQ-001 Parameter: EOL_CRLF, default 1, 1 = frame ends CR LF (0x0D 0x0A), 0 = LF only.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 report_req  input  1  one-cycle request to transmit one status frame.
REQ-005 mode  input  1  0 = watch frame, 1 = counter frame.
REQ-006 run  input  1  counter running flag (1 = run, 0 = stop).
REQ-007 up_down  input  1  counter direction (0 = up, 1 = down).
REQ-008 hour / min / sec / csec  input  5 / 6 / 6 / 7  watch time fields, binary.
REQ-009 count  input  14  counter value, binary.
REQ-010 tx_data  output  8  byte presented to the UART transmitter.
REQ-011 tx_start  output  1  one-cycle start strobe to the transmitter.
REQ-012 tx_busy / tx_done  input  1 / 1  transmitter busy level; one-cycle byte-complete pulse.
REQ-013 busy  output  1  high from request acceptance until frame end.
REQ-014 frame_done  output  1  one-cycle pulse after the last byte's tx_done.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, WAIT.
REQ-016 IDLE: report_req=1 -> snapshot mode, run, up_down, all fields; byte index 0; busy=1; go SEND next cycle.
REQ-017 report_req while busy=1 SHALL be ignored (no queueing, snapshot unchanged).
REQ-018 Watch frame: "W" HH ":" MM ":" SS "." CC EOL; 12 + EOL bytes (14 with CRLF).
REQ-019 Counter frame: "C" DDDD " " ("R" if run else "S") ("U" if up_down=0 else "D") EOL; 8 + EOL bytes (10 with CRLF).
REQ-020 Digits SHALL be ASCII decimal, zero-padded, most significant first.
REQ-021 Clamp: two-digit field > 99 prints "99"; count > 9999 prints "9999".
REQ-022 SEND: when tx_busy=0, tx_start=1 for exactly one cycle, go WAIT; when tx_busy=1, hold in SEND with tx_start=0.
REQ-023 tx_data SHALL equal the current frame byte throughout SEND and WAIT; 0x00 in IDLE.
REQ-024 WAIT: on tx_done, if last byte -> IDLE, frame_done=1 that cycle, busy=0 next cycle; else index+1, go SEND.
REQ-025 Minimum byte cadence: tx_start pulses separated by at least one SEND cycle after tx_done.
REQ-026 Output fields SHALL come from the snapshot only; input changes mid-frame SHALL NOT alter bytes.
REQ-027 tx_done received in IDLE or SEND SHALL be ignored.
REQ-028 report_req in the same cycle as frame_done SHALL be ignored (busy still 1).

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, index 0, tx_start=0, tx_data=0x00, busy=0, frame_done=0, snapshot cleared.
REQ-030 Reset asserted mid-frame SHALL abort the frame; no further tx_start until a new request after release.
REQ-031 First request accepted no earlier than the first clk edge after reset release.

Structure
REQ-032 Shared package uart_report_pkg SHALL hold FSM state encodings, ASCII constants ('W','C','R','S','U','D',':','.',' ',CR,LF), and frame-length constants.
REQ-033 One sub-module bin_to_ascii4 (14-bit binary in, clamped to 9999, four ASCII digits out) SHALL be used for count and, via the low two digits, each two-digit field.
REQ-034 Frame byte selection SHALL be a combinational mux on byte index and snapshot mode.

Verification
REQ-035 Watch: mode=0, hour=9, min=5, sec=59, csec=7, req -> bytes "W09:05:59.07" 0D 0A, 14 tx_start pulses, one frame_done.
REQ-036 Counter: mode=1, count=42, run=1, up_down=1, req -> "C0042 RD" 0D 0A; EOL_CRLF=0 -> "C0042 RD" 0A only.
REQ-037 Clamp: count=12000, csec=120 -> "C9999 ..." and watch field "99".
REQ-038 Back-pressure: tx_busy held 1 for 20 cycles in SEND -> tx_start stays 0, asserts once tx_busy falls; tx_data stable.
REQ-039 Busy request + snapshot: second req and count change during frame -> no second frame, bytes from first snapshot.
REQ-040 Reset at byte 5 of a watch frame -> outputs 0 immediately; after release a new req sends full frame from byte 0.

Source files
------------

// File: rtl/uart_report_pkg.sv
// Shared types and constants for the UART status reporter.
// Holds FSM states, ASCII symbols and frame length constants.
package uart_report_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT
   } state_t;

   localparam logic [7:0] ASC_W     = 8'h57;
   localparam logic [7:0] ASC_C     = 8'h43;
   localparam logic [7:0] ASC_R     = 8'h52;
   localparam logic [7:0] ASC_S     = 8'h53;
   localparam logic [7:0] ASC_U     = 8'h55;
   localparam logic [7:0] ASC_D     = 8'h44;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_DOT   = 8'h2E;
   localparam logic [7:0] ASC_SP    = 8'h20;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_0     = 8'h30;

   localparam int WATCH_BODY = 12;
   localparam int COUNT_BODY = 8;

   typedef struct packed {
      logic        mode;
      logic        run;
      logic        up_down;
      logic [4:0]  hour;
      logic [5:0]  min;
      logic [5:0]  sec;
      logic [6:0]  csec;
      logic [13:0] count;
   } snap_t;

   function automatic logic [13:0] clamp99(input logic [13:0] v);
      return (v > 14'd99) ? 14'd99 : v;
   endfunction

endpackage

// File: rtl/bin_to_ascii4.sv
// Binary to four zero-padded ASCII decimal digits.
// Inputs above 9999 saturate to "9999".
module bin_to_ascii4
   import uart_report_pkg::*;
(
   input  logic [13:0]     bin,
   output logic [3:0][7:0] digits
);

   logic [13:0] v;

   always_comb begin
      v = (bin > 14'd9999) ? 14'd9999 : bin;
      digits[3] = ASC_0 + 8'(v / 14'd1000);
      digits[2] = ASC_0 + 8'((v / 14'd100) % 14'd10);
      digits[1] = ASC_0 + 8'((v / 14'd10) % 14'd10);
      digits[0] = ASC_0 + 8'(v % 14'd10);
   end

endmodule

// File: rtl/uart_status_tx.sv
// Serialises a snapshot of watch or counter state as an ASCII
// status frame, one byte per transmitter handshake.
module uart_status_tx
   import uart_report_pkg::*;
#(
   parameter int EOL_CRLF = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        report_req,
   input  logic        mode,
   input  logic        run,
   input  logic        up_down,
   input  logic [4:0]  hour,
   input  logic [5:0]  min,
   input  logic [5:0]  sec,
   input  logic [6:0]  csec,
   input  logic [13:0] count,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic        busy,
   output logic        frame_done
);

   localparam int EOL_LEN = (EOL_CRLF != 0) ? 2 : 1;
   localparam logic [3:0] WATCH_LAST = 4'(WATCH_BODY + EOL_LEN - 1);
   localparam logic [3:0] COUNT_LAST = 4'(COUNT_BODY + EOL_LEN - 1);
   localparam logic [7:0] EOL_FIRST =
      (EOL_CRLF != 0) ? ASC_CR : ASC_LF;

   state_t          state;
   snap_t           snap;
   logic [3:0]      idx;
   logic            busy_q;
   logic [13:0]     conv_in;
   logic [3:0][7:0] dig;
   logic [7:0]      frame_byte;
   logic            last;

   // One converter, time-shared: the byte index picks the field.
   always_comb begin
      conv_in = snap.count;
      if (!snap.mode) begin
         unique case (idx)
            4'd1, 4'd2: conv_in = clamp99({9'd0, snap.hour});
            4'd4, 4'd5: conv_in = clamp99({8'd0, snap.min});
            4'd7, 4'd8: conv_in = clamp99({8'd0, snap.sec});
            default:    conv_in = clamp99({7'd0, snap.csec});
         endcase
      end
   end

   bin_to_ascii4 u_conv (
      .bin    (conv_in),
      .digits (dig)
   );

   always_comb begin
      frame_byte = 8'h00;
      if (!snap.mode) begin
         unique case (idx)
            4'd0:        frame_byte = ASC_W;
            4'd3, 4'd6:  frame_byte = ASC_COLON;
            4'd9:        frame_byte = ASC_DOT;
            4'd1, 4'd4,
            4'd7, 4'd10: frame_byte = dig[1];
            4'd2, 4'd5,
            4'd8, 4'd11: frame_byte = dig[0];
            4'd12:       frame_byte = EOL_FIRST;
            4'd13:       frame_byte = ASC_LF;
            default:     frame_byte = 8'h00;
         endcase
      end else begin
         unique case (idx)
            4'd0:    frame_byte = ASC_C;
            4'd1:    frame_byte = dig[3];
            4'd2:    frame_byte = dig[2];
            4'd3:    frame_byte = dig[1];
            4'd4:    frame_byte = dig[0];
            4'd5:    frame_byte = ASC_SP;
            4'd6:    frame_byte = snap.run ? ASC_R : ASC_S;
            4'd7:    frame_byte = snap.up_down ? ASC_D : ASC_U;
            4'd8:    frame_byte = EOL_FIRST;
            4'd9:    frame_byte = ASC_LF;
            default: frame_byte = 8'h00;
         endcase
      end
   end

   assign last = (idx == (snap.mode ? COUNT_LAST : WATCH_LAST));

   assign tx_data    = (state == ST_IDLE) ? 8'h00 : frame_byte;
   assign tx_start   = (state == ST_SEND) && !tx_busy;
   assign frame_done = (state == ST_WAIT) && tx_done && last;
   assign busy       = busy_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         idx    <= 4'd0;
         snap   <= '0;
         busy_q <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (report_req) begin
                  snap <= '{mode: mode, run: run,
                            up_down: up_down, hour: hour,
                            min: min, sec: sec, csec: csec,
                            count: count};
                  idx    <= 4'd0;
                  busy_q <= 1'b1;
                  state  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_busy) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_done) begin
                  if (last) begin
                     state  <= ST_IDLE;
                     idx    <= 4'd0;
                     busy_q <= 1'b0;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= ST_SEND;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_status_tx.sv
// Self-checking bench: two DUTs (CRLF and LF-only) against a
// string-formatting frame model, with simple transmitter models.
module tb_uart_status_tx;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        req_a, req_b, mode, run, up_down, hold_busy;
   logic [4:0]  hour;
   logic [5:0]  min, sec;
   logic [6:0]  csec;
   logic [13:0] count;

   logic [7:0] tx_data_a, tx_data_b;
   logic tx_start_a, tx_start_b, tx_busy_a, tx_busy_b;
   logic tx_done_a, tx_done_b, busy_a, busy_b, fd_a, fd_b;

   int checks = 0;
   int failures = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int fd_cnt_a = 0;
   int fd_cnt_b = 0;
   int cnt_a, cnt_b;

   uart_status_tx #(.EOL_CRLF(1)) dut_a (
      .clk(clk), .reset(reset), .report_req(req_a),
      .mode(mode), .run(run), .up_down(up_down),
      .hour(hour), .min(min), .sec(sec), .csec(csec),
      .count(count), .tx_data(tx_data_a),
      .tx_start(tx_start_a), .tx_busy(tx_busy_a),
      .tx_done(tx_done_a), .busy(busy_a), .frame_done(fd_a)
   );

   uart_status_tx #(.EOL_CRLF(0)) dut_b (
      .clk(clk), .reset(reset), .report_req(req_b),
      .mode(mode), .run(run), .up_down(up_down),
      .hour(hour), .min(min), .sec(sec), .csec(csec),
      .count(count), .tx_data(tx_data_b),
      .tx_start(tx_start_b), .tx_busy(tx_busy_b),
      .tx_done(tx_done_b), .busy(busy_b), .frame_done(fd_b)
   );

   // Transmitter models: random 1..4 cycle byte time.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_a <= 0;
         tx_done_a <= 1'b0;
      end else begin
         tx_done_a <= 1'b0;
         if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) tx_done_a <= 1'b1;
         end else if (tx_start_a) begin
            cnt_a <= int'($urandom_range(1, 4));
         end
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_b <= 0;
         tx_done_b <= 1'b0;
      end else begin
         tx_done_b <= 1'b0;
         if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) tx_done_b <= 1'b1;
         end else if (tx_start_b) begin
            cnt_b <= int'($urandom_range(1, 4));
         end
      end
   end

   assign tx_busy_a = (cnt_a != 0) || hold_busy;
   assign tx_busy_b = (cnt_b != 0) || hold_busy;

   always @(negedge clk) begin
      if (reset && tx_start_a) q_a.push_back(tx_data_a);
      if (reset && tx_start_b) q_b.push_back(tx_data_b);
      if (reset && fd_a) fd_cnt_a++;
      if (reset && fd_b) fd_cnt_b++;
   end

   task automatic chk(string name, bit ok, string act, string exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   function automatic int cl(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic string model(bit m, bit r, bit ud, int h,
                                   int mi, int s, int c, int cnt,
                                   bit crlf);
      string f;
      if (!m)
         f = $sformatf("W%02d:%02d:%02d.%02d", cl(h, 99),
                       cl(mi, 99), cl(s, 99), cl(c, 99));
      else
         f = $sformatf("C%04d %s%s", cl(cnt, 9999),
                       r ? "R" : "S", ud ? "D" : "U");
      if (crlf) f = {f, $sformatf("%c", 8'h0d)};
      return {f, $sformatf("%c", 8'h0a)};
   endfunction

   function automatic string hex_q(bit side, int base);
      string s = "";
      int n = side ? q_b.size() : q_a.size();
      for (int i = base; i < n; i++)
         s = {s, $sformatf("%02x", side ? q_b[i] : q_a[i])};
      return s;
   endfunction

   function automatic string hex_s(string e);
      string s = "";
      for (int i = 0; i < e.len(); i++)
         s = {s, $sformatf("%02x", e[i])};
      return s;
   endfunction

   function automatic string cur_model(bit crlf);
      return model(mode, run, up_down, int'(hour), int'(min),
                   int'(sec), int'(csec), int'(count), crlf);
   endfunction

   task automatic pulse_req(bit a, bit b);
      @(negedge clk);
      req_a = a;
      req_b = b;
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int i;
      for (i = 0; i < 3000; i++) begin
         if (!busy_a && !busy_b) break;
         @(negedge clk);
      end
      if (i == 3000) chk({name, "_timeout"}, 1'b0, "busy", "idle");
   endtask

   task automatic run_frame(string name);
      string ea, eb;
      int ba, bb, fa, fb;
      ea = cur_model(1'b1);
      eb = cur_model(1'b0);
      ba = q_a.size();
      bb = q_b.size();
      fa = fd_cnt_a;
      fb = fd_cnt_b;
      pulse_req(1'b1, 1'b1);
      wait_idle(name);
      chk({name, "_crlf"}, hex_q(1'b0, ba) == hex_s(ea),
          hex_q(1'b0, ba), hex_s(ea));
      chk({name, "_lf"}, hex_q(1'b1, bb) == hex_s(eb),
          hex_q(1'b1, bb), hex_s(eb));
      chk({name, "_fdone"},
          (fd_cnt_a - fa == 1) && (fd_cnt_b - fb == 1),
          $sformatf("%0d/%0d", fd_cnt_a - fa, fd_cnt_b - fb),
          "1/1");
   endtask

   typedef struct {
      bit    m, r, ud;
      int    h, mi, s, c, cnt;
      string txt;
   } vec_t;

   vec_t tbl[7];

   initial begin
      string exp_s;
      int base, i;
      bit bad;

      tbl[0] = '{0, 1, 0, 9, 5, 59, 7, 3, "W09:05:59.07"};
      tbl[1] = '{1, 1, 1, 17, 3, 8, 55, 42, "C0042 RD"};
      tbl[2] = '{1, 0, 0, 1, 2, 3, 120, 12000, "C9999 SU"};
      tbl[3] = '{0, 0, 1, 23, 0, 0, 120, 12000, "W23:00:00.99"};
      tbl[4] = '{0, 1, 1, 31, 63, 63, 99, 0, "W31:63:63.99"};
      tbl[5] = '{1, 1, 0, 0, 0, 0, 0, 9999, "C9999 RU"};
      tbl[6] = '{1, 0, 1, 4, 4, 4, 4, 0, "C0000 SD"};

      req_a = 0; req_b = 0; hold_busy = 0;
      mode = 0; run = 0; up_down = 0;
      hour = 0; min = 0; sec = 0; csec = 0; count = 0;

      repeat (3) @(negedge clk);
      chk("reset_outputs",
          tx_data_a == 8'h00 && !tx_start_a && !busy_a && !fd_a,
          $sformatf("%02x/%b/%b/%b", tx_data_a, tx_start_a,
                    busy_a, fd_a), "00/0/0/0");
      reset = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", !busy_a && tx_data_a == 8'h00,
          $sformatf("%b/%02x", busy_a, tx_data_a), "0/00");

      foreach (tbl[k]) begin
         mode = tbl[k].m; run = tbl[k].r; up_down = tbl[k].ud;
         hour = 5'(tbl[k].h); min = 6'(tbl[k].mi);
         sec = 6'(tbl[k].s); csec = 7'(tbl[k].c);
         count = 14'(tbl[k].cnt);
         exp_s = {tbl[k].txt, $sformatf("%c%c", 8'h0d, 8'h0a)};
         chk($sformatf("tbl%0d_model", k),
             cur_model(1'b1) == exp_s, cur_model(1'b1), exp_s);
         run_frame($sformatf("tbl%0d", k));
      end

      for (int n = 0; n < 25; n++) begin
         mode = 1'($urandom); run = 1'($urandom);
         up_down = 1'($urandom);
         hour = 5'($urandom); min = 6'($urandom);
         sec = 6'($urandom); csec = 7'($urandom);
         count = 14'($urandom);
         run_frame($sformatf("rand%0d", n));
      end

      // Back-pressure on the first byte.
      mode = 0; hour = 12; min = 34; sec = 56; csec = 78;
      exp_s = cur_model(1'b1);
      base = q_a.size();
      hold_busy = 1'b1;
      pulse_req(1'b1, 1'b0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (tx_start_a || tx_data_a != 8'h57 || !busy_a) bad = 1;
      end
      chk("bp_hold", !bad, $sformatf("%b", bad), "0");
      hold_busy = 1'b0;
      #1;
      chk("bp_release", tx_start_a == 1'b1,
          $sformatf("%b", tx_start_a), "1");
      wait_idle("bp");
      chk("bp_frame", hex_q(1'b0, base) == hex_s(exp_s),
          hex_q(1'b0, base), hex_s(exp_s));

      // Snapshot held; requests while busy and on frame_done ignored.
      mode = 1; count = 42; run = 1; up_down = 1;
      exp_s = cur_model(1'b1);
      base = q_a.size();
      i = fd_cnt_a;
      pulse_req(1'b1, 1'b0);
      repeat (5) @(negedge clk);
      count = 7777; mode = 0; run = 0;
      pulse_req(1'b1, 1'b0);
      bad = 1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (fd_a) begin
            bad = 0;
            break;
         end
      end
      chk("snap_fdone_seen", !bad, $sformatf("%b", !bad), "1");
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      repeat (30) @(negedge clk);
      chk("snap_idle", !busy_a, $sformatf("%b", busy_a), "0");
      chk("snap_frame", hex_q(1'b0, base) == hex_s(exp_s),
          hex_q(1'b0, base), hex_s(exp_s));
      chk("snap_one_fdone", fd_cnt_a - i == 1,
          $sformatf("%0d", fd_cnt_a - i), "1");

      // Reset mid-frame, then a clean frame.
      mode = 0; hour = 9; min = 5; sec = 59; csec = 7;
      base = q_a.size();
      pulse_req(1'b1, 1'b0);
      bad = 1;
      for (int k = 0; k < 2000; k++) begin
         if (q_a.size() - base >= 5) begin
            bad = 0;
            break;
         end
         @(negedge clk);
      end
      chk("rst_reach_byte5", !bad, $sformatf("%0d",
          q_a.size() - base), ">=5");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_async",
          tx_data_a == 8'h00 && !tx_start_a && !busy_a && !fd_a,
          $sformatf("%02x/%b/%b/%b", tx_data_a, tx_start_a,
                    busy_a, fd_a), "00/0/0/0");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      base = q_a.size();
      repeat (20) @(negedge clk);
      chk("rst_no_start", q_a.size() == base,
          $sformatf("%0d", q_a.size() - base), "0");
      run_frame("rst_new");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
